// File: rtl/static_bus_tx.sv
// static_bus_tx: source-side driver for a quasi-static bus that crosses into
// another clock domain through a per-bit two-flop synchronizer. Each accepted
// word is registered onto bus_data and then frozen for HOLD_CYCLES cycles, so
// the far side only ever samples a settled, coherent word.
//
// Optional build macro: STATIC_BUS_TX_DEDUP_EN
//   defined   - an accept whose data equals the current bus word completes the
//               handshake but leaves the bus, counter and state untouched
//   undefined - every accept is a full update with a hold window
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus settled, in_ready=1, next accepted word is driven out
// HOLD  | bus frozen after an update, in_ready=0, bus_busy=1
module static_bus_tx #(
    parameter int                    DATA_WIDTH  = 4,
    parameter int                    HOLD_CYCLES = 8,
    parameter int                    CNT_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_busy,
    output logic [CNT_WIDTH-1:0]  upd_cnt
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // A zero-length hold would let the bus change under the far-side synchronizer.
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("static_bus_tx: HOLD_CYCLES must be >= 1");
    end

    logic [0:0]     state;
    logic [HCW-1:0] hold_cnt;
    logic           accept;
    logic           same_word;
    logic           do_update;

    // Handshake outputs come from state only, never from in_valid.
    always_comb begin
        in_ready = (state == ST_IDLE);
        bus_busy = (state == ST_HOLD);
    end

    // Decide whether an accept turns into a real bus update.
    always_comb begin
        accept = in_valid & in_ready;
`ifdef STATIC_BUS_TX_DEDUP_EN
        same_word = (in_data == bus_data);
`else
        same_word = 1'b0;
`endif
        do_update = accept & ~same_word;
    end

    // Bus register, hold timer (down-counter to zero) and update counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bus_data <= RESET_VALUE;
            hold_cnt <= '0;
            upd_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_update) begin
                        bus_data <= in_data;
                        hold_cnt <= HOLD_LOAD;
                        upd_cnt  <= upd_cnt + CNT_WIDTH'(1);
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_static_bus_tx.sv
// Directed bench for static_bus_tx: one instance with HOLD_CYCLES=4 and an
// 8-bit counter, plus a second instance with a 2-bit counter for wrap-around.
module tb_static_bus_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid;
    logic [3:0] a_data;
    logic       a_ready;
    logic [3:0] a_bus;
    logic       a_busy;
    logic [7:0] a_cnt;

    logic       b_valid;
    logic [3:0] b_data;
    logic       b_ready;
    logic [3:0] b_bus;
    logic       b_busy;
    logic [1:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    static_bus_tx #(
        .DATA_WIDTH (4),
        .HOLD_CYCLES(4),
        .CNT_WIDTH  (8),
        .RESET_VALUE(4'h0)
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .in_valid(a_valid),
        .in_ready(a_ready),
        .in_data (a_data),
        .bus_data(a_bus),
        .bus_busy(a_busy),
        .upd_cnt (a_cnt)
    );

    static_bus_tx #(
        .DATA_WIDTH (4),
        .HOLD_CYCLES(4),
        .CNT_WIDTH  (2),
        .RESET_VALUE(4'h0)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .in_valid(b_valid),
        .in_ready(b_ready),
        .in_data (b_data),
        .bus_data(b_bus),
        .bus_busy(b_busy),
        .upd_cnt (b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] bus, input logic rdy,
                         input logic busy, input logic [7:0] cnt);
        chk({tag, ".bus"},   32'(a_bus),   32'(bus));
        chk({tag, ".ready"}, 32'(a_ready), 32'(rdy));
        chk({tag, ".busy"},  32'(a_busy),  32'(busy));
        chk({tag, ".cnt"},   32'(a_cnt),   32'(cnt));
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 4'h0;
        b_valid = 1'b0;
        b_data  = 4'h0;

        // Reset state
        reset_all();
        chk_a("reset", 4'h0, 1'b1, 1'b0, 8'd0);
        chk("reset.b_cnt", 32'(b_cnt), 32'd0);

        // Single update of 4'hA; data changes while holding are ignored
        a_valid = 1'b1;
        a_data  = 4'hA;
        tick();
        a_valid = 1'b0;
        a_data  = 4'hF;
        chk_a("single.h0", 4'hA, 1'b0, 1'b1, 8'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_a("single.hold", 4'hA, 1'b0, 1'b1, 8'd1);
        end
        tick();
        chk_a("single.done", 4'hA, 1'b1, 1'b0, 8'd1);

        // Request held during hold is not accepted
        a_valid = 1'b1;
        a_data  = 4'h3;
        tick();
        chk_a("ignore.acc", 4'h3, 1'b0, 1'b1, 8'd2);
        a_data = 4'h9;
        tick();
        chk_a("ignore.held", 4'h3, 1'b0, 1'b1, 8'd2);
        a_valid = 1'b0;
        tick();
        tick();
        tick();
        chk_a("ignore.done", 4'h3, 1'b1, 1'b0, 8'd2);

        // Back-to-back: accepts every HOLD_CYCLES+1 edges
        reset_all();
        a_valid = 1'b1;
        a_data  = 4'h1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_a("b2b.acc", 4'(k), 1'b0, 1'b1, 8'(k));
            a_data = 4'(k + 1);
            for (int i = 1; i < 4; i++) begin
                tick();
                chk_a("b2b.hold", 4'(k), 1'b0, 1'b1, 8'(k));
            end
            tick();
            chk_a("b2b.idle", 4'(k), 1'b1, 1'b0, 8'(k));
        end
        a_valid = 1'b0;
        tick();
        chk_a("b2b.end", 4'h3, 1'b1, 1'b0, 8'd3);

        // Reset in the 2nd hold cycle, with a request pending at the reset edge
        a_valid = 1'b1;
        a_data  = 4'h7;
        tick();
        a_valid = 1'b0;
        chk_a("midrst.acc", 4'h7, 1'b0, 1'b1, 8'd4);
        tick();
        chk_a("midrst.h2", 4'h7, 1'b0, 1'b1, 8'd4);
        rst     = 1'b1;
        a_valid = 1'b1;
        a_data  = 4'hE;
        tick();
        rst     = 1'b0;
        a_valid = 1'b0;
        chk_a("midrst.after", 4'h0, 1'b1, 1'b0, 8'd0);
        tick();
        chk_a("midrst.stay", 4'h0, 1'b1, 1'b0, 8'd0);

        // Equal-data request
        a_valid = 1'b1;
        a_data  = 4'h5;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_a("dup.setup", 4'h5, 1'b1, 1'b0, 8'd1);
        a_valid = 1'b1;
        a_data  = 4'h5;
        tick();
        a_valid = 1'b0;
`ifdef STATIC_BUS_TX_DEDUP_EN
        chk_a("dup.skip", 4'h5, 1'b1, 1'b0, 8'd1);
        a_valid = 1'b1;
        a_data  = 4'h6;
        tick();
        a_valid = 1'b0;
        chk_a("dup.next", 4'h6, 1'b0, 1'b1, 8'd2);
`else
        chk_a("dup.full", 4'h5, 1'b0, 1'b1, 8'd2);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_a("dup.hold", 4'h5, 1'b0, 1'b1, 8'd2);
        end
        tick();
        chk_a("dup.done", 4'h5, 1'b1, 1'b0, 8'd2);
`endif

        // 2-bit counter wrap on instance B
        for (int k = 0; k < 5; k++) begin
            b_valid = 1'b1;
            b_data  = 4'(k + 1);
            tick();
            b_valid = 1'b0;
            chk("wrap.cnt", 32'(b_cnt), 32'(wrap_exp[k]));
            chk("wrap.bus", 32'(b_bus), 32'(k + 1));
            for (int i = 0; i < 4; i++) tick();
            chk("wrap.ready", 32'(b_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
